// File: rtl/load_channel_responder.sv
// Load-channel slave: turns load requests into word reads on the memory bus, buffers one
// back-to-back request, and answers with an error on timeout. Optional reuse register: LOAD_REUSE_EN.
module load_channel_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_request_i,
  input  logic [31:0] load_address_i,
  output logic        load_ready_o,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,
  output logic        load_error_o,
  output logic        mem_read_o,
  output logic [31:0] mem_address_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  input  logic        store_valid_i,
  input  logic [31:0] store_address_i,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DATA} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [29:0]   pend_addr_q, pend_addr_d;
  logic [29:0]   addr_q, addr_d;
  logic          drain_q, drain_d;
  logic          lvalid_q, lvalid_d;
  logic          lerr_q, lerr_d;
  logic [31:0]   ldata_q, ldata_d;
  logic          mread_q, mread_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          req_ok, data_hit, timeout, finish;
  logic          fill_evt, err_evt;
  logic          reuse_hit;
  logic [31:0]   reuse_data;
  logic [1:0]    unused_load_lo;

  assign unused_load_lo = load_address_i[1:0];

`ifdef LOAD_REUSE_EN
  logic        ru_valid_q, ru_valid_d;
  logic [29:0] ru_tag_q, ru_tag_d;
  logic [31:0] ru_data_q, ru_data_d;
  logic [1:0]  unused_store_lo;

  assign unused_store_lo = store_address_i[1:0];
  // A store to the same word in the hitting cycle forces the request to memory.
  assign reuse_hit  = ru_valid_q && (ru_tag_q == load_address_i[31:2]) &&
                      !(store_valid_i && (store_address_i[31:2] == load_address_i[31:2]));
  assign reuse_data = ru_data_q;

  always_comb begin
    ru_valid_d = ru_valid_q;
    ru_tag_d   = ru_tag_q;
    ru_data_d  = ru_data_q;
    if (fill_evt) begin
      ru_valid_d = 1'b1;
      ru_tag_d   = addr_q;
      ru_data_d  = mem_data_i;
    end else if (err_evt) begin
      ru_valid_d = 1'b0;
    end
    if (store_valid_i && (store_address_i[31:2] == ru_tag_d)) ru_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ru_valid_q <= 1'b0;
      ru_tag_q   <= '0;
      ru_data_q  <= '0;
    end else begin
      ru_valid_q <= ru_valid_d;
      ru_tag_q   <= ru_tag_d;
      ru_data_q  <= ru_data_d;
    end
  end
`else
  logic unused_store;

  assign unused_store = store_valid_i ^ (^store_address_i);
  assign reuse_hit    = 1'b0;
  assign reuse_data   = '0;
`endif

  assign req_ok   = load_request_i && ready_q;
  assign data_hit = mem_valid_i && !drain_q && (state_q == S_WAIT_DATA);
  assign timeout  = (state_q != S_IDLE) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    addr_d      = addr_q;
    drain_d     = drain_q;
    lvalid_d    = 1'b0;
    lerr_d      = 1'b0;
    ldata_d     = '0;
    finish      = 1'b0;
    fill_evt    = 1'b0;
    err_evt     = 1'b0;

    // The first read data after a timed-out accepted read belongs to that read.
    if (drain_q && mem_valid_i) drain_d = 1'b0;

    if (req_ok && (state_q != S_IDLE)) begin
      pend_d      = 1'b1;
      pend_addr_d = load_address_i[31:2];
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          addr_d  = pend_addr_q;
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else if (req_ok) begin
          if (reuse_hit) begin
            lvalid_d = 1'b1;
            ldata_d  = reuse_data;
          end else begin
            addr_d  = load_address_i[31:2];
            cnt_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE, S_WAIT_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if ((state_q == S_ISSUE) && mem_accept_i) state_d = S_WAIT_DATA;
        if (data_hit) begin
          lvalid_d = 1'b1;
          ldata_d  = mem_data_i;
          fill_evt = 1'b1;
          finish   = 1'b1;
        end else if (timeout) begin
          lvalid_d = 1'b1;
          lerr_d   = 1'b1;
          err_evt  = 1'b1;
          finish   = 1'b1;
          if ((state_q == S_WAIT_DATA) || mem_accept_i) drain_d = 1'b1;
        end
        if (finish) begin
          if (pend_q) begin
            addr_d  = pend_addr_q;
            pend_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    mread_d = (state_d == S_ISSUE);
    ready_d = !pend_d;
    busy_d  = (state_d != S_IDLE) || pend_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      addr_q      <= '0;
      drain_q     <= 1'b0;
      lvalid_q    <= 1'b0;
      lerr_q      <= 1'b0;
      ldata_q     <= '0;
      mread_q     <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      lvalid_q    <= lvalid_d;
      lerr_q      <= lerr_d;
      ldata_q     <= ldata_d;
      mread_q     <= mread_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign load_ready_o  = ready_q;
  assign load_valid_o  = lvalid_q;
  assign load_error_o  = lerr_q;
  assign load_data_o   = ldata_q;
  assign mem_read_o    = mread_q;
  assign mem_address_o = {addr_q, 2'b00};
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_load_channel_responder.sv
// Scoreboard bench for load_channel_responder: issuer pushes expected responses and memory
// plans, a memory model serves reads, a monitor pops and compares every response.
module tb_load_channel_responder;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst_n_i, load_request_i, load_ready_o, load_valid_o, load_error_o;
  logic [31:0] load_address_i, load_data_o, mem_address_o, mem_data_i, store_address_i;
  logic        mem_read_o, mem_accept_i, mem_valid_i, store_valid_i, busy_o;

  always #5 clk = ~clk;

  load_channel_responder #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .load_request_i(load_request_i), .load_address_i(load_address_i),
    .load_ready_o(load_ready_o), .load_valid_o(load_valid_o),
    .load_data_o(load_data_o), .load_error_o(load_error_o),
    .mem_read_o(mem_read_o), .mem_address_o(mem_address_o),
    .mem_accept_i(mem_accept_i), .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .store_valid_i(store_valid_i), .store_address_i(store_address_i),
    .busy_o(busy_o)
  );

  // mode: 0 = answer with data, 1 = accept then stay silent, 2 = accept then abandoned by reset
  typedef struct { int mode; int da; int dd; int late; logic [31:0] data; } plan_t;
  typedef struct { logic err; logic [31:0] data; } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          resp_cnt = 0;
  time         resp_time = 0;

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Issue one legal request at the current negedge; returns at the following negedge.
  task automatic do_req(input logic [31:0] a, input int mode, input int da, input int dd,
                        input int late, input logic [31:0] d, output time t0);
    int   g;
    plan_t p;
    exp_t  e;
    g = 0;
    while (load_ready_o !== 1'b1 && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk({31'b0, load_ready_o}, 32'd1, "ready_wait");
    p.mode = mode; p.da = da; p.dd = dd; p.late = late; p.data = d;
    plan_q.push_back(p);
    addr_q.push_back(a & 32'hFFFF_FFFC);
    if (mode == 0) begin e.err = 1'b0; e.data = d; exp_q.push_back(e); end
    if (mode == 1) begin e.err = 1'b1; e.data = '0; exp_q.push_back(e); end
    load_request_i = 1'b1;
    load_address_i = a;
    t0 = $time;
    @(negedge clk);
    load_request_i = 1'b0;
  endtask

  task automatic wait_resp(input int prev);
    int g;
    g = 0;
    while (resp_cnt == prev && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk(resp_cnt, prev + 1, "resp_wait");
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy_o !== 1'b0 || exp_q.size() != 0 || plan_q.size() != 0) && g < 1000) begin
      @(negedge clk); g++;
    end
    if (g >= 1000) chk({31'b0, busy_o}, 32'd0, "idle_wait");
    repeat (4) @(negedge clk);
  endtask

  // Memory model
  initial begin
    plan_t       p;
    logic [31:0] ea;
    int          g;
    mem_accept_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
    @(negedge clk);
    forever begin
      if (mem_read_o === 1'b1 && rst_n_i === 1'b1) begin
        if (plan_q.size() == 0) begin
          chk({31'b0, mem_read_o}, 32'd0, "unexpected_read");
          @(negedge clk);
        end else begin
          p  = plan_q.pop_front();
          ea = addr_q.pop_front();
          chk(mem_address_o, ea, "mem_addr");
          for (int k = 0; k < p.da; k++) begin
            @(negedge clk);
            chk({31'b0, mem_read_o}, 32'd1, "read_held");
            chk(mem_address_o, ea, "addr_stable");
          end
          mem_accept_i = 1'b1;
          @(negedge clk);
          mem_accept_i = 1'b0;
          chk({31'b0, mem_read_o}, 32'd0, "read_drop");
          if (p.mode == 0) begin
            repeat (p.dd - 1) @(negedge clk);
            mem_valid_i = 1'b1; mem_data_i = p.data;
            @(negedge clk);
            mem_valid_i = 1'b0; mem_data_i = $urandom;
          end else if (p.mode == 1) begin
            g = 0;
            while (load_valid_o !== 1'b1 && g < 40) begin @(negedge clk); g++; end
            if (g >= 40) chk({31'b0, load_valid_o}, 32'd1, "timeout_wait");
            repeat (p.late) @(negedge clk);
            mem_valid_i = 1'b1; mem_data_i = 32'h0000_1234;
            @(negedge clk);
            mem_valid_i = 1'b0;
          end else begin
            repeat (3) @(negedge clk);
            mem_valid_i = 1'b1; mem_data_i = 32'h5555_5555;
            @(negedge clk);
            mem_valid_i = 1'b0;
          end
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n_i === 1'b1 && load_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk({31'b0, load_valid_o}, 32'd0, "unexpected_resp");
        end else begin
          e = exp_q.pop_front();
          chk({31'b0, load_error_o}, {31'b0, e.err}, "resp_err");
          chk(load_data_o, e.data, "resp_data");
        end
        resp_time = $time;
        resp_cnt++;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({31'b0, load_valid_o}, 32'd0, {tag, "_valid"});
    chk({31'b0, load_error_o}, 32'd0, {tag, "_error"});
    chk({31'b0, mem_read_o},   32'd0, {tag, "_mem_read"});
    chk({31'b0, busy_o},       32'd0, {tag, "_busy"});
    chk({31'b0, load_ready_o}, 32'd1, {tag, "_ready"});
    chk(load_data_o,   32'd0, {tag, "_data"});
    chk(mem_address_o, 32'd0, {tag, "_mem_addr"});
  endtask

  initial begin
    time         t0;
    int          c, da, dd, nz;
    logic [31:0] a;
    exp_t        e;

    rst_n_i = 1'b0; load_request_i = 1'b0; load_address_i = '0;
    store_valid_i = 1'b0; store_address_i = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n_i = 1'b1;
    @(negedge clk);

    // Zero-wait read: response three cycles after the request
    c = resp_cnt;
    do_req(32'h0000_1006, 0, 0, 1, 0, 32'hDEAD_BEEF, t0);
    wait_resp(c);
    chk(32'(resp_time - t0), 32'd30, "latency_min");
    wait_idle();

    // Accept withheld 3 cycles
    c = resp_cnt;
    do_req(32'h0000_2468, 0, 3, 2, 0, mem_word(32'h0000_2468), t0);
    wait_resp(c);
    chk(32'(resp_time - t0), 32'd70, "latency_wait3");
    wait_idle();

    // Data arriving in the timeout cycle wins
    c = resp_cnt;
    do_req(32'h0000_6000, 0, 3, 4, 0, mem_word(32'h0000_6000), t0);
    wait_resp(c);
    chk(32'(resp_time - t0), 32'd90, "latency_boundary");
    wait_idle();

    // Timeout in WAIT_DATA, late data discarded, next request gets its own data
    c = resp_cnt;
    do_req(32'h0000_4000, 1, 0, 1, 1, 32'h0, t0);
    wait_resp(c);
    chk(32'(resp_time - t0), 32'(10 * (T + 1)), "timeout_latency");
    c = resp_cnt;
    do_req(32'h0000_5000, 0, 0, 1, 0, mem_word(32'h0000_5000), t0);
    wait_resp(c);
    wait_idle();

    // Back-to-back: second request lands in the pending buffer
    do_req(32'h0000_1000, 0, 0, 3, 0, mem_word(32'h0000_1000), t0);
    @(negedge clk);
    do_req(32'h0000_2000, 0, 1, 1, 0, mem_word(32'h0000_2000), t0);
    chk({31'b0, load_ready_o}, 32'd0, "ready_low_pending");
    wait_idle();
    chk({31'b0, load_ready_o}, 32'd1, "ready_restored");

`ifdef LOAD_REUSE_EN
    c = resp_cnt;
    do_req(32'h0000_3000, 0, 0, 1, 0, 32'h0000_00AA, t0);
    wait_resp(c);
    wait_idle();
    e.err = 1'b0; e.data = 32'h0000_00AA; exp_q.push_back(e);
    c = resp_cnt;
    load_request_i = 1'b1; load_address_i = 32'h0000_3000; t0 = $time;
    @(negedge clk);
    load_request_i = 1'b0;
    chk({31'b0, mem_read_o}, 32'd0, "reuse_no_read");
    wait_resp(c);
    chk(32'(resp_time - t0), 32'd10, "reuse_latency");
    store_valid_i = 1'b1; store_address_i = 32'h0000_3002;
    @(negedge clk);
    store_valid_i = 1'b0;
    c = resp_cnt;
    do_req(32'h0000_3000, 0, 0, 1, 0, 32'h0000_00BB, t0);
    wait_resp(c);
    chk(32'(resp_time - t0), 32'd30, "reuse_after_store");
    wait_idle();
`endif

    // Randomized traffic, including silent memory and dropped illegal requests
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (load_ready_o === 1'b0 && $urandom_range(0, 2) == 0) begin
        load_request_i = 1'b1; load_address_i = $urandom;
        @(negedge clk);
        load_request_i = 1'b0;
      end else begin
        a  = $urandom;
        da = $urandom_range(0, 2);
        dd = $urandom_range(1, 3);
        if ($urandom_range(0, 7) == 0) do_req(a, 1, da, 1, $urandom_range(0, 1), 32'h0, t0);
        else do_req(a, 0, da, dd, 0, mem_word(a), t0);
      end
    end
    wait_idle();

    // Reset while in WAIT_DATA abandons the read; its late data is ignored
    do_req(32'h0000_7000, 2, 0, 0, 0, 32'h0, t0);
    @(negedge clk);
    rst_n_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    chk_reset_outputs("midreset");
    nz = 0;
    repeat (8) begin @(negedge clk); if (load_valid_o !== 1'b0) nz++; end
    chk(nz, 32'd0, "no_resp_after_reset");
    c = resp_cnt;
    do_req(32'h0000_8000, 0, 0, 1, 0, mem_word(32'h0000_8000), t0);
    wait_resp(c);
    chk(32'(resp_time - t0), 32'd30, "latency_after_reset");
    wait_idle();

    chk(exp_q.size(), 32'd0, "responses_outstanding");
    chk(plan_q.size(), 32'd0, "reads_outstanding");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/load_channel_responder.md
Name: load_channel_responder

Overview:
- Slave end of the load channel. Accepts word-granular load requests (request + address) from the load unit.
- Issues reads to the memory bus (request/accept, then data valid) and returns a one-cycle data-valid pulse with the read word.
- Holds a 1-entry pending buffer so a back-to-back request is not lost.
- Has a watchdog timeout that answers with an error if memory never responds.
- Sits between the load unit and the memory/bus controller.

Parameters:
- TIMEOUT_CYCLES, 64: cycles from entering ISSUE until a forced error response; legal range ≥2. Counter width is $clog2(TIMEOUT_CYCLES)+1.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset: synchronous, active-low (one clock; polarity and synchronicity fixed)
- load_request_i  in  1  load unit request strobe, single cycle
- load_address_i  in  32  byte address; bits [1:0] ignored
- load_ready_o  out  1  pending buffer free; a request is legal only when this is 1
- load_valid_o  out  1  response valid, one-cycle pulse
- load_data_o  out  32  response word; 0 on error
- load_error_o  out  1  timeout error, qualified by load_valid_o
- mem_read_o  out  1  memory read request, held until accepted
- mem_address_o  out  32  word-aligned address; [1:0] = 0
- mem_accept_i  in  1  memory accepted the read
- mem_valid_i  in  1  read data valid
- mem_data_i  in  32  read data
- store_valid_i  in  1  store snoop strobe (used only with the optional feature)
- store_address_i  in  32  store snoop address
- busy_o  out  1  state != IDLE or pending entry valid

Behaviour:
- Reset (rst_n_i = 0 at a clock edge):
  - state = IDLE; pending, drain and timeout counter cleared.
  - Outputs: load_valid_o, load_error_o, mem_read_o, busy_o = 0; load_data_o, mem_address_o = 0; load_ready_o = 1.
  - Reset mid-transaction abandons the in-flight read with no response. Any later mem_valid_i is not matched to a request and is ignored.
- All outputs are registered.
- States:
  - IDLE:
    - Source is load_request_i, or the pending entry, with pending taking priority.
    - Latch word address, go to ISSUE, clear the counter. mem_read_o is high from the next cycle.
  - ISSUE:
    - Hold mem_read_o = 1 and a stable mem_address_o.
    - On mem_accept_i: drop mem_read_o next cycle and go to WAIT_DATA. The counter keeps running.
  - WAIT_DATA:
    - On mem_valid_i: next cycle drive load_valid_o = 1, load_data_o = mem_data_i, load_error_o = 0.
    - Then go to ISSUE if pending is valid (consuming it), else IDLE.
- Timeout:
  - Counter increments every cycle in ISSUE and WAIT_DATA.
  - When it reaches TIMEOUT_CYCLES-1 with no data: respond load_valid_o = 1, load_error_o = 1, load_data_o = 0; drop mem_read_o; go to IDLE (or ISSUE if pending).
  - If the timeout occurs in WAIT_DATA (read was accepted), set drain. The next mem_valid_i is discarded and clears drain.
  - While drain is set, a new read may issue, but its first mem_valid_i is consumed by drain.
- Same-cycle mem_valid_i and timeout: data wins; no error.
- Pending buffer:
  - A request while busy (state != IDLE) is stored in pending; load_ready_o = 0 from the next cycle.
  - A request with load_ready_o = 0 is a protocol violation: it is dropped and pending is unchanged.
- Latency, no wait states: request at cycle N, mem_accept_i at N+1, mem_valid_i at N+2 → load_valid_o at N+3.
- Exactly one response per accepted request, in order.

Optional Feature:
- LOAD_REUSE_EN. When defined, adds a 1-entry reuse register (tag = address[31:2], data, valid).
  - Fill on every non-error memory response. Invalidate on any error.
  - Invalidate when store_valid_i is high and store_address_i[31:2] matches the tag.
  - In IDLE, a new request whose word address matches a valid entry responds at N+1 with the stored data. No memory read is issued and state stays IDLE.
  - Store snoop in the same cycle as a hitting request: treated as a miss (store wins).
- When undefined: no reuse register; store_valid_i and store_address_i are unused; every request goes to memory.

Test Plan:
- Reset then request 0x0000_1006, mem_accept_i immediate, mem_valid_i next cycle with 0xDEAD_BEEF → mem_address_o = 0x0000_1004; load_valid_o at N+3 with 0xDEAD_BEEF, error 0.
- mem_accept_i withheld 3 cycles → mem_read_o held 4 cycles with a stable address; response follows mem_valid_i by 1 cycle.
- TIMEOUT_CYCLES = 8, read accepted, memory silent → load_valid_o = 1, load_error_o = 1, data 0 at cycle 8; a late mem_valid_i carrying 0x1234 is discarded; the next request returns its own data.
- Second request (0x2000) while the first (0x1000) is in WAIT_DATA → load_ready_o = 0; responses come in order 0x1000 then 0x2000; load_ready_o returns to 1.
- LOAD_REUSE_EN: load 0x3000 → 0xAA; reload 0x3000 → response at N+1, no mem_read_o; store to 0x3002, then reload → mem_read_o issued.
- Assert rst_n_i in WAIT_DATA → next cycle all outputs at reset values; the following mem_valid_i produces no load_valid_o.
